// File: rtl/led_pwm_seq.sv
// ---------------------------------------------------------------------------
// led_pwm_seq
//
// Multi-channel LED PWM generator. Each channel has a shadow duty register
// (written at any time) and an active duty register (used by the comparator).
// Shadows are copied into the active registers only on the period wrap, so a
// duty change never cuts a period short or stretches it. A rotation sequencer
// can shift the shadow duties one channel up every DWELL periods.
//
// Optional feature macro: LED_BREATHE_EN
//   Defined   : mode 2 scales every channel's duty by a triangular brightness
//               envelope that steps once per PWM period.
//   Undefined : mode 2 behaves exactly like static mode and no envelope logic
//               exists.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   enable       run the PWM counter; low freezes the counter, blanks outputs
//   mode         0 static, 1 rotate, 2 breathe, 3 reserved (static)
//   duty_wr      one-cycle duty write strobe
//   duty_ch      channel targeted by duty_wr (out-of-range writes ignored)
//   duty_data    duty value written to the shadow register
//   pwm_out      registered PWM outputs, one per channel
//   period_tick  one-cycle pulse in the cycle where the counter is 0
// ---------------------------------------------------------------------------
module led_pwm_seq #(
    parameter int CHANNELS   = 3,
    parameter int PWM_BITS   = 8,
    parameter int DWELL      = 64,
    parameter int DWELL_BITS = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [1:0]                  mode,
    input  logic                        duty_wr,
    input  logic [$clog2(CHANNELS)-1:0] duty_ch,
    input  logic [PWM_BITS-1:0]         duty_data,
    output logic [CHANNELS-1:0]         pwm_out,
    output logic                        period_tick
);

    localparam int CH_BITS = $clog2(CHANNELS);

    typedef enum logic [1:0] {
        MODE_STATIC   = 2'd0,
        MODE_ROTATE   = 2'd1,
        MODE_BREATHE  = 2'd2,
        MODE_RESERVED = 2'd3
    } mode_t;

    logic [PWM_BITS-1:0]   cnt_q, cnt_d;
    logic [PWM_BITS-1:0]   shadow_q [CHANNELS];
    logic [PWM_BITS-1:0]   shadow_d [CHANNELS];
    logic [PWM_BITS-1:0]   active_q [CHANNELS];
    logic [PWM_BITS-1:0]   active_d [CHANNELS];
    logic [PWM_BITS-1:0]   eff_sel  [CHANNELS];
    logic [DWELL_BITS-1:0] dwell_q, dwell_d;
    mode_t                 mode_q, mode_d;
    logic [CHANNELS-1:0]   pwm_q, pwm_d;
    logic                  tick_q, tick_d;
    logic                  wrap;
    logic                  rotate;

`ifdef LED_BREATHE_EN
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [PWM_BITS-1:0] bright_q, bright_d;
    dir_t                dir_q, dir_d;
    logic [PWM_BITS-1:0] eff_q [CHANNELS];
    logic [PWM_BITS-1:0] eff_d [CHANNELS];
`endif

    // Counter, duty registers, sequencer and output compare.
    // The mode input is latched only on a wrap so a mode change never splits
    // a period between two behaviours.
    always_comb begin
        wrap   = enable && (cnt_q == '1);
        cnt_d  = enable ? cnt_q + 1'b1 : cnt_q;
        mode_d = wrap ? mode_t'(mode) : mode_q;
        rotate = wrap && (mode_q == MODE_ROTATE) &&
                 (dwell_q == DWELL_BITS'(DWELL - 1));

        // Rotation happens first so that a write in the same cycle wins.
        for (int i = 0; i < CHANNELS; i++) begin
            shadow_d[i] = rotate ? shadow_q[(i + CHANNELS - 1) % CHANNELS]
                                 : shadow_q[i];
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (duty_wr && (duty_ch == CH_BITS'(i))) begin
                shadow_d[i] = duty_data;
            end
        end

        // Active takes the next-state shadow, including a same-cycle write.
        for (int i = 0; i < CHANNELS; i++) begin
            active_d[i] = wrap ? shadow_d[i] : active_q[i];
        end

        if (mode_q != MODE_ROTATE) begin
            dwell_d = '0;
        end else if (rotate) begin
            dwell_d = '0;
        end else if (wrap) begin
            dwell_d = dwell_q + 1'b1;
        end else begin
            dwell_d = dwell_q;
        end

`ifdef LED_BREATHE_EN
        bright_d = bright_q;
        dir_d    = dir_q;
        if (mode_q != MODE_BREATHE) begin
            bright_d = '0;
            dir_d    = DIR_UP;
        end else if (wrap) begin
            if (dir_q == DIR_UP) begin
                bright_d = bright_q + 1'b1;
                if (bright_d == '1) begin
                    dir_d = DIR_DOWN;
                end
            end else begin
                bright_d = bright_q - 1'b1;
                if (bright_d == '0) begin
                    dir_d = DIR_UP;
                end
            end
        end

        // Scaled duty is captured at the wrap together with the new active
        // value, so it stays constant for the whole period.
        for (int i = 0; i < CHANNELS; i++) begin
            eff_d[i] = wrap ? PWM_BITS'(((2 * PWM_BITS)'(active_d[i]) *
                                         (2 * PWM_BITS)'(bright_d)) >> PWM_BITS)
                            : eff_q[i];
            eff_sel[i] = (mode_q == MODE_BREATHE) ? eff_q[i] : active_q[i];
        end
`else
        for (int i = 0; i < CHANNELS; i++) begin
            eff_sel[i] = active_q[i];
        end
`endif

        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = enable && (cnt_q < eff_sel[i]);
        end
        tick_d = wrap;
    end

    // All state registers, cleared together by the synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            dwell_q <= '0;
            mode_q  <= MODE_STATIC;
            pwm_q   <= '0;
            tick_q  <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
`ifdef LED_BREATHE_EN
            bright_q <= '0;
            dir_q    <= DIR_UP;
            for (int i = 0; i < CHANNELS; i++) begin
                eff_q[i] <= '0;
            end
`endif
        end else begin
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            mode_q  <= mode_d;
            pwm_q   <= pwm_d;
            tick_q  <= tick_d;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
`ifdef LED_BREATHE_EN
            bright_q <= bright_d;
            dir_q    <= dir_d;
            for (int i = 0; i < CHANNELS; i++) begin
                eff_q[i] <= eff_d[i];
            end
`endif
        end
    end

    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;

endmodule
